mulu_seq_x2y2_ctrl: RTL and testbench

Sequential controller that computes a wide unsigned product X_WIDTH x Y_WIDTH using one shared 2x2 unsigned multiplier tile (mulu_x2y2).
- Splits both operands into 2-bit digits and walks every digit pair, one pair per clock.
- Shifts each 4-bit tile product into place and accumulates it.
- Uses a valid/ready handshake on both input and output.
- Sits between the project I/O wrapper and the multiplier tile, giving a large multiplier built from a small datapath.

---
 rtl/mulu_pkg.sv | 17 +
 rtl/mulu_x2y2.sv | 30 +++
 rtl/mulu_seq_x2y2_ctrl.sv | 150 +++++++++++++++
 tb/tb_mulu_seq_x2y2_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mulu_pkg.sv
// Shared types and constants for the digit-serial unsigned multiplier.
// Digit width and digit-count helper used by controller and tile builds.
package mulu_pkg;

  localparam int DIGIT_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int digit_count(input int width);
    return width / DIGIT_WIDTH;
  endfunction

endpackage

// File: rtl/mulu_x2y2.sv
// Small unsigned multiplier tile, X_WIDTH x Y_WIDTH (2x2 in the controller).
// Latency: combinational, product valid in the same cycle as the operands.
// Backpressure: none; optional rdy output is tied high.
module mulu_x2y2 #(
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2
) (
`ifdef HAS_SIGN
  output logic                       s,
`endif
`ifdef HAS_READY
  output logic                       rdy,
`endif
  input  logic [X_WIDTH-1:0]         a,
  input  logic [Y_WIDTH-1:0]         b,
  output logic [X_WIDTH+Y_WIDTH-1:0] p
);

  localparam int PW = X_WIDTH + Y_WIDTH;

  assign p = PW'(a) * PW'(b);

`ifdef HAS_SIGN
  assign s = 1'b0;
`endif
`ifdef HAS_READY
  assign rdy = 1'b1;
`endif

endmodule

// File: rtl/mulu_seq_x2y2_ctrl.sv
// Wide unsigned multiplier built by walking 2-bit digit pairs through one 2x2 tile.
// Latency: NX*NY busy cycles; out_valid rises NX*NY+1 edges after accept.
// Backpressure: result held in DONE until out_ready; no accept while BUSY or DONE.
module mulu_seq_x2y2_ctrl
  import mulu_pkg::*;
#(
  parameter  int X_WIDTH = 8,
  parameter  int Y_WIDTH = 8,
  localparam int P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] p,
  output logic               busy
);

  localparam int NX  = digit_count(X_WIDTH);
  localparam int NY  = digit_count(Y_WIDTH);
  localparam int IXW = (NX > 1) ? $clog2(NX) : 1;
  localparam int IYW = (NY > 1) ? $clog2(NY) : 1;
  localparam int SW  = $clog2(P_WIDTH);
  localparam int TW  = 2 * DIGIT_WIDTH;

  state_t               state_q, state_d;
  logic [X_WIDTH-1:0]   x_r;
  logic [Y_WIDTH-1:0]   y_r;
  logic [P_WIDTH-1:0]   acc;
  logic [IXW-1:0]       ix;
  logic [IYW-1:0]       iy;
  logic                 accept;
  logic                 step;
  logic                 cancel;
  logic                 ix_last;
  logic                 iy_last;
  logic [DIGIT_WIDTH-1:0] x_dig;
  logic [DIGIT_WIDTH-1:0] y_dig;
  logic [TW-1:0]        tile_p;
  logic [SW-1:0]        shamt;
  logic [P_WIDTH-1:0]   term;

  assign ix_last = (ix == IXW'(NX - 1));
  assign iy_last = (iy == IYW'(NY - 1));

  assign x_dig = x_r[{ix, 1'b0} +: DIGIT_WIDTH];
  assign y_dig = y_r[{iy, 1'b0} +: DIGIT_WIDTH];

  mulu_x2y2 #(
    .X_WIDTH(DIGIT_WIDTH),
    .Y_WIDTH(DIGIT_WIDTH)
  ) u_tile (
`ifdef HAS_SIGN
    .s   (),
`endif
`ifdef HAS_READY
    .rdy (),
`endif
    .a   (x_dig),
    .b   (y_dig),
    .p   (tile_p)
  );

  // Digit weight is 4^(ix+iy); max shift P_WIDTH-4 fits in SW bits.
  assign shamt = (SW'(ix) + SW'(iy)) << 1;
  assign term  = P_WIDTH'(tile_p) << shamt;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    cancel    = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !abort) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (abort) begin
          cancel  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (ix_last && iy_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (abort) begin
          cancel  = 1'b1;
          state_d = ST_IDLE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r <= '0;
      y_r <= '0;
      acc <= '0;
      ix  <= '0;
      iy  <= '0;
    end else if (cancel) begin
      acc <= '0;
      ix  <= '0;
      iy  <= '0;
    end else if (accept) begin
      x_r <= x;
      y_r <= y;
      acc <= '0;
      ix  <= '0;
      iy  <= '0;
    end else if (step) begin
      acc <= acc + term;
      if (ix_last) begin
        ix <= '0;
        iy <= iy_last ? '0 : iy + 1'b1;
      end else begin
        ix <= ix + 1'b1;
      end
    end
  end

  assign p = out_valid ? acc : '0;

endmodule

// File: tb/tb_mulu_seq_x2y2_ctrl.sv
// Directed bench for the digit-serial multiplier: default 8x8 build plus a 4x8 build.
module tb_mulu_seq_x2y2_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [7:0]  x, y;
  logic [15:0] p;

  logic        in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b, busy_b;
  logic [3:0]  x_b;
  logic [7:0]  y_b;
  logic [11:0] p_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mulu_seq_x2y2_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  mulu_seq_x2y2_ctrl #(.X_WIDTH(4), .Y_WIDTH(8)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .x         (x_b),
    .y         (y_b),
    .abort     (abort_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .p         (p_b),
    .busy      (busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Waits out BUSY with a bound; returns the number of busy cycles seen.
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  task automatic do_op(input logic [7:0] xv, input logic [7:0] yv,
                       input logic [15:0] ep, input string tag);
    int cnt;
    chk({tag, "_in_ready"}, in_ready, 1);
    x = xv; y = yv; in_valid = 1'b1;
    step();
    in_valid = 1'b0; x = '0; y = '0;
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    wait_busy(cnt);
    chk({tag, "_busy_cycles"}, cnt, 16);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_p"}, p, ep);
    step();
    chk({tag, "_released"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_p_zero"}, p, 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    in_valid_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1; x_b = '0; y_b = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    step();

    do_op(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
    do_op(8'h0D, 8'h0B, 16'h008F, "0d_0b");
    do_op(8'h00, 8'hAB, 16'h0000, "00_ab");

    // Back-pressure: result held while out_ready is low.
    out_ready = 1'b0;
    x = 8'h12; y = 8'h34; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_busy(cnt);
    chk("bp_busy_cycles", cnt, 16);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_p", p, 16'h03A8);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_one_handshake", out_valid, 0);
    chk("bp_idle", in_ready, 1);

    // Operands offered during BUSY/DONE are ignored until back in IDLE.
    x = 8'h02; y = 8'h03; in_valid = 1'b1;
    step();
    x = 8'h77; y = 8'h77;
    wait_busy(cnt);
    chk("ign_busy_cycles", cnt, 16);
    chk("ign_p", p, 16'h0006);
    step();
    chk("ign_idle_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("ign_second_accept", busy, 1);
    wait_busy(cnt);
    chk("ign_second_p", p, 16'h3751);
    step();

    // Synchronous reset in the middle of BUSY.
    x = 8'hFF; y = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("mid_rst_busy_before", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_p", p, 0);

    // Abort at BUSY cycle 3.
    x = 8'hFF; y = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_p", p, 0);
    repeat (18) begin
      chk("abort_no_valid", out_valid, 0);
      step();
    end

    // Abort wins over a handshake in IDLE.
    abort = 1'b1; in_valid = 1'b1; x = 8'h55; y = 8'h55;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle_no_accept", busy, 0);

    // Abort while holding a result in DONE.
    out_ready = 1'b0;
    x = 8'h11; y = 8'h11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_busy(cnt);
    chk("abort_done_valid", out_valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0; out_ready = 1'b1;
    chk("abort_done_drop", out_valid, 0);
    chk("abort_done_idle", in_ready, 1);

    do_op(8'h80, 8'h02, 16'h0100, "80_02");

    // 4x8 build: 2x4 digit pairs.
    chk("b_in_ready", in_ready_b, 1);
    x_b = 4'hF; y_b = 8'hFF; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    cnt = 0;
    while (busy_b === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("b_busy_cycles", cnt, 8);
    chk("b_out_valid", out_valid_b, 1);
    chk("b_p", p_b, 12'h0EF1);
    step();
    chk("b_released", out_valid_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
